fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
- Upstream controller for fetch_instruction.
- Owns the program counter and issues memory read requests.
- Raises a one-cycle fetch_enable so fetch_instruction latches the returned word, then holds in an execute window until the downstream stages release it.
- Sequences sequential, branch and halt flow for the binary 16-bit core.

Parameters:
- WORD_SIZE, 16, instruction width (informational; matches fetch_instruction).
- ADDR_WIDTH, 8, program counter / instruction address width.
- RESET_VECTOR, 0, PC value loaded on reset.

Ports:
- clock  input  1  single system clock; all state updates on posedge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  level; begins fetching from IDLE.
- halt_req  input  1  request to stop after the current instruction.
- stall  input  1  downstream busy; holds EXECUTE.
- branch_taken  input  1  redirect PC at the end of EXECUTE.
- branch_target  input  ADDR_WIDTH  redirect address.
- mem_ready  input  1  instruction memory has valid data for pc.
- pc  output  ADDR_WIDTH  current instruction address.
- mem_read  output  1  read request to instruction memory.
- fetch_enable  output  1  drives fetch_instruction.fetch_enable.
- instr_valid  output  1  latched instruction is valid for decode.
- halted  output  1  sequencer stopped.
- state  output  3  current state encoding (debug).
- retired_count  output  16  instructions completed, saturating.

Behaviour:
- Reset (async, reset_n=0):
  - Immediately: state=IDLE, pc=RESET_VECTOR, retired_count=0.
  - mem_read, fetch_enable, instr_valid and halted all 0.
  - Reset asserted mid-operation aborts any state with no further outputs.
- All outputs are Moore and decoded from registered state, so there are no combinational input-to-output paths.
- States: IDLE=0, REQUEST=1, LATCH=2, EXECUTE=3, HALTED=4. Codes 5-7 are illegal and recover to IDLE on the next edge.
- IDLE:
  - All strobes 0.
  - If halt_req=1, go to HALTED. halt_req has priority over start.
  - Else if start=1, go to REQUEST.
- REQUEST:
  - mem_read=1, pc stable.
  - If mem_ready=1 at the edge, go to LATCH; otherwise stay. No timeout.
- LATCH:
  - fetch_enable=1 for exactly one cycle; mem_read=0.
  - fetch_instruction captures the memory word at the closing edge.
  - Unconditionally go to EXECUTE.
- EXECUTE:
  - instr_valid=1.
  - stall=1: stay, with pc, count and fetch_enable=0 held.
  - stall=0, priority order:
    - halt_req=1: go to HALTED, pc unchanged.
    - Else branch_taken=1: pc<=branch_target, go to REQUEST.
    - Else: pc<=pc+1 modulo 2^ADDR_WIDTH (max address wraps to 0), go to REQUEST.
  - Every exit from EXECUTE increments retired_count. It saturates at 16'hFFFF and never wraps.
- HALTED:
  - halted=1, other strobes 0.
  - Left only via reset; start is ignored.
- Inputs are ignored outside the states listed above:
  - mem_ready outside REQUEST.
  - branch_taken/branch_target outside EXECUTE, or while stall=1.
  - start outside IDLE.
- Latency:
  - start sampled at edge k gives mem_read=1 after k.
  - With mem_ready high, minimum period is 3 cycles per instruction (REQUEST, LATCH, EXECUTE).
  - A fetch_enable pulse always precedes instr_valid by exactly one cycle.

Decomposition:
- Shared header fetch_defs.vh holds:
  - State code constants (IDLE..HALTED).
  - STATE_WIDTH=3.
  - Default WORD_SIZE/ADDR_WIDTH, also used by fetch_instruction and the decode stage.
- Sub-module program_counter:
  - Registered pc with async active-low reset to RESET_VECTOR.
  - Inputs: load, load_value, increment.
  - load has priority over increment.
- Top level holds the FSM and the saturating retired counter.

Test Plan:
- Reset then start=1, mem_ready=1 -> mem_read at pc=0x00, fetch_enable one cycle later, instr_valid the next cycle. Together with fetch_instruction, the instruction equals the 16'hABCD memory word; pc becomes 0x01; retired_count=1.
- mem_ready low for 4 cycles in REQUEST -> mem_read held, pc=0x05 stable, no fetch_enable until mem_ready rises.
- EXECUTE with stall=1 for 3 cycles, then branch_taken=1, branch_target=0x40 -> instr_valid held 4 cycles, pc=0x40 next, count increments once.
- pc=0xFF, sequential completion -> pc wraps to 0x00. Preload retired_count to 0xFFFF via 65535 completions or a forced value -> stays 0xFFFF.
- halt_req=1 together with branch_taken=1 in EXECUTE -> HALTED, halted=1, pc unchanged; later start=1 is ignored.
- reset_n pulsed low mid-LATCH (between clock edges) -> fetch_enable drops immediately, state=IDLE, pc=RESET_VECTOR, count=0.

Source files
------------

// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the fetch sequencer: state codes, default widths
// and the saturating retire-count helper.
package fetch_sequencer_pkg;

  localparam int STATE_WIDTH    = 3;
  localparam int DEF_WORD_SIZE  = 16;
  localparam int DEF_ADDR_WIDTH = 8;
  localparam int COUNT_WIDTH    = 16;

  typedef enum logic [STATE_WIDTH-1:0] {
    ST_IDLE    = 3'd0,
    ST_REQUEST = 3'd1,
    ST_LATCH   = 3'd2,
    ST_EXECUTE = 3'd3,
    ST_HALTED  = 3'd4
  } state_e;

  function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v);
    return (v == {COUNT_WIDTH{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/fetch_sequencer_program_counter.sv
// Program counter register: load wins over increment, wraps modulo 2^ADDR_WIDTH.
module program_counter #(
  parameter int                    ADDR_WIDTH   = 8,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic                  clock_i,
  input  logic                  reset_n_i,
  input  logic                  load_i,
  input  logic [ADDR_WIDTH-1:0] load_value_i,
  input  logic                  increment_i,
  output logic [ADDR_WIDTH-1:0] pc_o
);

  logic [ADDR_WIDTH-1:0] pc_q;
  logic [ADDR_WIDTH-1:0] pc_d;

  always_comb begin
    pc_d = pc_q;
    if (load_i) begin
      pc_d = load_value_i;
    end else if (increment_i) begin
      pc_d = pc_q + 1'b1;
    end
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      pc_q <= RESET_VECTOR;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: owns the PC, requests instruction words, pulses fetch_enable
// and holds an execute window until downstream releases it.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int                    WORD_SIZE    = DEF_WORD_SIZE,
  parameter int                    ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic                   halt_req,
  input  logic                   stall,
  input  logic                   branch_taken,
  input  logic [ADDR_WIDTH-1:0]  branch_target,
  input  logic                   mem_ready,
  output logic [ADDR_WIDTH-1:0]  pc,
  output logic                   mem_read,
  output logic                   fetch_enable,
  output logic                   instr_valid,
  output logic                   halted,
  output logic [STATE_WIDTH-1:0] state,
  output logic [COUNT_WIDTH-1:0] retired_count
);

  // WORD_SIZE only documents the width shared with fetch_instruction.
  if (WORD_SIZE != DEF_WORD_SIZE) begin : g_nonstandard_word
  end

  state_e                 state_q;
  logic [COUNT_WIDTH-1:0] retired_q;
  logic                   retire;
  logic                   pc_load;
  logic                   pc_inc;

  assign retire = (state_q == ST_EXECUTE) && !stall;

  always_comb begin
    pc_load = 1'b0;
    pc_inc  = 1'b0;
    if (retire && !halt_req) begin
      if (branch_taken) begin
        pc_load = 1'b1;
      end else begin
        pc_inc = 1'b1;
      end
    end
  end

  program_counter #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .RESET_VECTOR(RESET_VECTOR)
  ) u_pc (
    .clock_i     (clock),
    .reset_n_i   (reset_n),
    .load_i      (pc_load),
    .load_value_i(branch_target),
    .increment_i (pc_inc),
    .pc_o        (pc)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      retired_q <= '0;
    end else begin
      if (retire) begin
        retired_q <= sat_inc(retired_q);
      end
      case (state_q)
        ST_IDLE: begin
          if (halt_req) begin
            state_q <= ST_HALTED;
          end else if (start) begin
            state_q <= ST_REQUEST;
          end
        end
        ST_REQUEST: begin
          if (mem_ready) begin
            state_q <= ST_LATCH;
          end
        end
        ST_LATCH: state_q <= ST_EXECUTE;
        ST_EXECUTE: begin
          if (!stall) begin
            state_q <= halt_req ? ST_HALTED : ST_REQUEST;
          end
        end
        ST_HALTED: state_q <= ST_HALTED;
        // Illegal encodings fall back to IDLE.
        default:   state_q <= ST_IDLE;
      endcase
    end
  end

  // Moore outputs decoded from the registered state only.
  assign mem_read      = (state_q == ST_REQUEST);
  assign fetch_enable  = (state_q == ST_LATCH);
  assign instr_valid   = (state_q == ST_EXECUTE);
  assign halted        = (state_q == ST_HALTED);
  assign state         = state_q;
  assign retired_count = retired_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios plus a random run
// compared against a behavioural reference model.
module tb_fetch_sequencer;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        halt_req = 1'b0;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [7:0]  branch_target = 8'h00;
  logic        mem_ready = 1'b0;
  logic [7:0]  pc;
  logic        mem_read;
  logic        fetch_enable;
  logic        instr_valid;
  logic        halted;
  logic [2:0]  state;
  logic [15:0] retired_count;

  int checks = 0;
  int errors = 0;

  // Reference model: 0 idle, 1 request, 2 latch, 3 execute, 4 halted
  int          m_st;
  logic [7:0]  m_pc;
  logic [15:0] m_cnt;

  fetch_sequencer dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .start        (start),
    .halt_req     (halt_req),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .mem_ready    (mem_ready),
    .pc           (pc),
    .mem_read     (mem_read),
    .fetch_enable (fetch_enable),
    .instr_valid  (instr_valid),
    .halted       (halted),
    .state        (state),
    .retired_count(retired_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs();
    chk("state", {29'd0, state}, m_st);
    chk("pc", {24'd0, pc}, {24'd0, m_pc});
    chk("retired_count", {16'd0, retired_count}, {16'd0, m_cnt});
    chk("mem_read", {31'd0, mem_read}, (m_st == 1) ? 1 : 0);
    chk("fetch_enable", {31'd0, fetch_enable}, (m_st == 2) ? 1 : 0);
    chk("instr_valid", {31'd0, instr_valid}, (m_st == 3) ? 1 : 0);
    chk("halted", {31'd0, halted}, (m_st == 4) ? 1 : 0);
  endtask

  task automatic model_reset();
    m_st  = 0;
    m_pc  = 8'h00;
    m_cnt = 16'h0000;
  endtask

  // One clock: predict from the inputs applied now, then compare after the edge.
  task automatic step();
    int          n_st;
    logic [7:0]  n_pc;
    logic [15:0] n_cnt;
    n_st  = m_st;
    n_pc  = m_pc;
    n_cnt = m_cnt;
    if (m_st == 0) begin
      if (halt_req) n_st = 4;
      else if (start) n_st = 1;
    end else if (m_st == 1) begin
      if (mem_ready) n_st = 2;
    end else if (m_st == 2) begin
      n_st = 3;
    end else if (m_st == 3 && !stall) begin
      n_cnt = (m_cnt == 16'hFFFF) ? 16'hFFFF : m_cnt + 16'd1;
      if (halt_req) n_st = 4;
      else begin
        n_st = 1;
        n_pc = branch_taken ? branch_target : 8'((int'(m_pc) + 1) % 256);
      end
    end
    @(posedge clock);
    #1;
    m_st  = n_st;
    m_pc  = n_pc;
    m_cnt = n_cnt;
    check_outputs();
  endtask

  // Reset pulse placed between clock edges; outputs must clear immediately.
  task automatic do_reset();
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    chk("async_rst_fetch_enable", {31'd0, fetch_enable}, 0);
    check_outputs();
    #2 reset_n = 1'b1;
  endtask

  task automatic run_until(input int st, input int pcv, input int budget, input string tag);
    int n = 0;
    while (!(m_st == st && int'(m_pc) == pcv) && n < budget) begin
      step();
      n++;
    end
    chk({tag, "_reached"}, (m_st == st && int'(m_pc) == pcv) ? 1 : 0, 1);
  endtask

  logic [7:0] saved_pc;
  int         halt_cycles;

  initial begin
    model_reset();
    #12;
    check_outputs();
    #1 reset_n = 1'b1;

    // First fetch from the reset vector
    start = 1'b1; mem_ready = 1'b1;
    step();
    chk("first_mem_read_pc", {24'd0, pc}, 0);
    start = 1'b0;
    step();
    step();
    step();
    chk("first_retire_pc", {24'd0, pc}, 1);
    chk("first_retire_count", {16'd0, retired_count}, 1);

    // Memory not ready for four cycles at pc 0x05
    run_until(1, 5, 40, "pc5");
    mem_ready = 1'b0;
    repeat (4) step();
    chk("wait_pc_stable", {24'd0, pc}, 5);
    mem_ready = 1'b1;
    step();
    step();

    // Stall in EXECUTE, then branch to 0x40
    stall = 1'b1;
    repeat (3) step();
    stall = 1'b0; branch_taken = 1'b1; branch_target = 8'h40;
    step();
    branch_taken = 1'b0;
    chk("branch_pc", {24'd0, pc}, 32'h40);

    // Branch to 0xFF, then sequential wrap to 0x00
    step(); step();
    branch_taken = 1'b1; branch_target = 8'hFF;
    step();
    branch_taken = 1'b0;
    step(); step(); step();
    chk("wrap_pc", {24'd0, pc}, 0);

    // Retire counter saturation
    step(); step();
    stall = 1'b1;
    force dut.retired_q = 16'hFFFE;
    #1 release dut.retired_q;
    m_cnt = 16'hFFFE;
    step();
    stall = 1'b0;
    step();
    chk("sat_reach", {16'd0, retired_count}, 32'hFFFF);
    step(); step(); step();
    chk("sat_hold", {16'd0, retired_count}, 32'hFFFF);

    // Halt has priority over branch; start is ignored afterwards
    step(); step();
    saved_pc = m_pc;
    halt_req = 1'b1; branch_taken = 1'b1; branch_target = 8'h77;
    step();
    halt_req = 1'b0; branch_taken = 1'b0; start = 1'b1;
    repeat (3) step();
    chk("halt_pc_unchanged", {24'd0, pc}, {24'd0, saved_pc});
    chk("halt_sticky", {31'd0, halted}, 1);

    // Reset in the middle of LATCH
    do_reset();
    step();
    step();
    start = 1'b0;
    chk("latch_before_reset", {31'd0, fetch_enable}, 1);
    do_reset();

    // Randomized run against the model
    halt_cycles = 0;
    for (int i = 0; i < 600; i++) begin
      start         = 1'($urandom_range(0, 1));
      halt_req      = ($urandom_range(0, 39) == 0);
      stall         = ($urandom_range(0, 2) == 0);
      branch_taken  = ($urandom_range(0, 3) == 0);
      branch_target = 8'($urandom);
      mem_ready     = 1'($urandom_range(0, 1));
      step();
      if (m_st == 4) halt_cycles++;
      if (halt_cycles > 3) begin
        halt_cycles = 0;
        do_reset();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
